// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state and grant encodings for the Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   // MAX_OUTSTANDING is bounded to 15, so four bits always suffice
   localparam int CNT_W = 4;

   function automatic logic [1:0] grant_of(arb_state_t st);
      case (st)
         GNT0:    return GRANT_M0;
         GNT1:    return GRANT_M1;
         default: return GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - two pipelined Wishbone masters, one shared slave, grant
interface wb_bus_arbiter_if;

   logic        m0_cyc, m0_stb, m0_we;
   logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
   logic [3:0]  m0_sel;
   logic        m0_stall, m0_ack, m0_err;

   logic        m1_cyc, m1_stb, m1_we;
   logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
   logic [3:0]  m1_sel;
   logic        m1_stall, m1_ack, m1_err;

   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic [3:0]  s_sel;
   logic        s_stall, s_ack, s_err;

   logic [1:0]  grant;

   modport arb (
      input  m0_cyc, m0_stb, m0_we, m0_adr, m0_sel, m0_dat_w,
      output m0_stall, m0_ack, m0_err, m0_dat_r,
      input  m1_cyc, m1_stb, m1_we, m1_adr, m1_sel, m1_dat_w,
      output m1_stall, m1_ack, m1_err, m1_dat_r,
      output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w,
      input  s_stall, s_ack, s_err, s_dat_r,
      output grant
   );

   modport master (
      output m0_cyc, m0_stb, m0_we, m0_adr, m0_sel, m0_dat_w,
      input  m0_stall, m0_ack, m0_err, m0_dat_r,
      output m1_cyc, m1_stb, m1_we, m1_adr, m1_sel, m1_dat_w,
      input  m1_stall, m1_ack, m1_err, m1_dat_r,
      input  grant
   );

   modport slave (
      input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w,
      output s_stall, s_ack, s_err, s_dat_r
   );

endinterface

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - watchdog counting cycles without a slave response
module wb_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count,
   input  logic clear,
   output logic expire
);

   localparam logic [31:0] LIMIT  = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          ENABLE = (TIMEOUT_CYCLES != 0);

   logic [31:0] timer;

   // A response arriving in the expiry cycle wins over the abort
   assign expire = ENABLE && count && !clear && (timer == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (clear || expire) begin
         timer <= '0;
      end else if (count) begin
         timer <= timer + 32'd1;
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin arbiter for two pipelined Wishbone masters
// Grant is held until the owner drops cyc; a watchdog aborts a silent slave.
module wb_bus_arbiter
   import wb_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input logic           clk,
   input logic           rst_n,
   wb_bus_arbiter_if.arb bus
);

   arb_state_t       state, state_nxt;
   logic             last_m1, last_m1_nxt;
   logic             aborted, aborted_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic        own_cyc, own_stb, own_we;
   logic [31:0] own_adr, own_dat_w;
   logic [3:0]  own_sel;
   logic        granted, full, pending, live, own0, own1;
   logic        tmr_count, tmr_clear, expire, resp, accept;

   assign own_cyc   = (state == GNT1) ? bus.m1_cyc   : bus.m0_cyc;
   assign own_stb   = (state == GNT1) ? bus.m1_stb   : bus.m0_stb;
   assign own_we    = (state == GNT1) ? bus.m1_we    : bus.m0_we;
   assign own_adr   = (state == GNT1) ? bus.m1_adr   : bus.m0_adr;
   assign own_sel   = (state == GNT1) ? bus.m1_sel   : bus.m0_sel;
   assign own_dat_w = (state == GNT1) ? bus.m1_dat_w : bus.m0_dat_w;

   assign granted   = (state != IDLE);
   assign full      = (cnt == CNT_W'(MAX_OUTSTANDING));
   assign pending   = (cnt != '0);
   // Responses with nothing outstanding are stray and never reach a master
   assign tmr_count = granted && !aborted && own_cyc && pending;
   assign resp      = tmr_count && (bus.s_ack || bus.s_err);
   assign tmr_clear = !tmr_count || resp;
   assign live      = granted && !aborted && !expire;
   assign own0      = live && (state == GNT0);
   assign own1      = live && (state == GNT1);
   assign accept    = bus.s_stb && !bus.s_stall;

   wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .count  (tmr_count),
      .clear  (tmr_clear),
      .expire (expire)
   );

   assign bus.s_cyc   = live && own_cyc;
   assign bus.s_stb   = live && own_stb && !full;
   assign bus.s_we    = live && own_we;
   assign bus.s_adr   = live ? own_adr   : '0;
   assign bus.s_sel   = live ? own_sel   : '0;
   assign bus.s_dat_w = live ? own_dat_w : '0;
   assign bus.grant   = grant_of(state);

   assign bus.m0_stall = !own0 || bus.s_stall || full;
   assign bus.m0_ack   = own0 && resp && bus.s_ack;
   assign bus.m0_err   = (state == GNT0) && ((live && resp && bus.s_err) || expire);
   assign bus.m0_dat_r = own0 ? bus.s_dat_r : '0;

   assign bus.m1_stall = !own1 || bus.s_stall || full;
   assign bus.m1_ack   = own1 && resp && bus.s_ack;
   assign bus.m1_err   = (state == GNT1) && ((live && resp && bus.s_err) || expire);
   assign bus.m1_dat_r = own1 ? bus.s_dat_r : '0;

   always_comb begin
      state_nxt   = state;
      last_m1_nxt = last_m1;
      aborted_nxt = aborted;
      cnt_nxt     = cnt;
      case (state)
         IDLE: begin
            if (bus.m0_cyc && bus.m1_cyc) begin
               state_nxt   = last_m1 ? GNT0 : GNT1;
               last_m1_nxt = !last_m1;
            end else if (bus.m0_cyc) begin
               state_nxt   = GNT0;
               last_m1_nxt = 1'b0;
            end else if (bus.m1_cyc) begin
               state_nxt   = GNT1;
               last_m1_nxt = 1'b1;
            end
         end
         default: begin
            if (!own_cyc) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               aborted_nxt = 1'b0;
            end else if (expire) begin
               aborted_nxt = 1'b1;
               cnt_nxt     = '0;
            end else if (!aborted) begin
               if (accept && !resp) begin
                  cnt_nxt = cnt + 1'b1;
               end else if (resp && !accept) begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last_m1 <= 1'b0;
         aborted <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         last_m1 <= last_m1_nxt;
         aborted <= aborted_nxt;
         cnt     <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed and randomized checks for wb_bus_arbiter
module tb_wb_bus_arbiter;

   localparam int MAXO = 4;
   localparam int TMO  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   wb_bus_arbiter_if bus();

   wb_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.m0_cyc = 0; bus.m0_stb = 0; bus.m0_we = 0; bus.m0_adr = 0; bus.m0_sel = 0; bus.m0_dat_w = 0;
      bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0; bus.m1_adr = 0; bus.m1_sel = 0; bus.m1_dat_w = 0;
      bus.s_stall = 0; bus.s_ack = 0; bus.s_err = 0; bus.s_dat_r = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.m0_cyc = 1; bus.m1_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'hdead_beef;
      bus.s_ack = 1; bus.s_err = 1; bus.s_dat_r = 32'hffff_ffff;
      step();
      step();
      checks++;
      if ({bus.grant, bus.s_cyc, bus.s_stb, bus.s_we} !== 5'b0) begin
         errors++; $display("FAIL reset_slave_ctl: got %b want 00000", {bus.grant, bus.s_cyc, bus.s_stb, bus.s_we});
      end
      checks++;
      if ({bus.m0_stall, bus.m1_stall, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 6'b110000) begin
         errors++; $display("FAIL reset_master_resp: got %b want 110000",
            {bus.m0_stall, bus.m1_stall, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err});
      end
      checks++;
      if ({bus.m0_dat_r, bus.m1_dat_r, bus.s_adr, bus.s_dat_w, bus.s_sel} !== 132'b0) begin
         errors++; $display("FAIL reset_data: m0_dat_r=%h m1_dat_r=%h s_adr=%h want all 0", bus.m0_dat_r, bus.m1_dat_r, bus.s_adr);
      end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      do_reset();
      bus.m0_cyc = 1;
      #1;
      checks++;
      if (bus.grant !== 2'b00 || bus.m0_stall !== 1'b1) begin
         errors++; $display("FAIL arb_latency: grant=%b m0_stall=%b want 00/1", bus.grant, bus.m0_stall);
      end
      step();
      checks++;
      if (bus.grant !== 2'b01) begin
         errors++; $display("FAIL grant_m0: got %b want 01", bus.grant);
      end
      bus.m0_stb = 1; bus.m0_adr = 32'h0000_0080; bus.m0_sel = 4'hf;
      #1;
      checks++;
      if ({bus.s_cyc, bus.s_stb, bus.m0_stall} !== 3'b110 || bus.s_adr !== 32'h0000_0080 || bus.s_sel !== 4'hf) begin
         errors++; $display("FAIL read_request: cyc/stb/stall=%b adr=%h want 110 00000080",
            {bus.s_cyc, bus.s_stb, bus.m0_stall}, bus.s_adr);
      end
      step();
      bus.m0_stb = 0; bus.s_ack = 1; bus.s_dat_r = 32'h1234_5678;
      #1;
      checks++;
      if (bus.m0_ack !== 1'b1 || bus.m0_dat_r !== 32'h1234_5678) begin
         errors++; $display("FAIL read_data: ack=%b dat=%h want 1 12345678", bus.m0_ack, bus.m0_dat_r);
      end
      checks++;
      if ({bus.m1_ack, bus.m1_err, bus.m1_stall} !== 3'b001 || bus.m1_dat_r !== 32'h0) begin
         errors++; $display("FAIL other_master_quiet: ack/err/stall=%b dat=%h want 001 0",
            {bus.m1_ack, bus.m1_err, bus.m1_stall}, bus.m1_dat_r);
      end
      step();
      bus.s_ack = 0; bus.m0_cyc = 0;
      #1;
      checks++;
      if (bus.s_cyc !== 1'b0) begin
         errors++; $display("FAIL cyc_follow: s_cyc=%b want 0", bus.s_cyc);
      end
      step();
      checks++;
      if (bus.grant !== 2'b00) begin
         errors++; $display("FAIL release_m0: grant=%b want 00", bus.grant);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.m0_cyc = 1; bus.m1_cyc = 1;
      step();
      checks++;
      if (bus.grant !== 2'b10) begin
         errors++; $display("FAIL first_contention: grant=%b want 10", bus.grant);
      end
      step();
      step();
      #1;
      checks++;
      if (bus.grant !== 2'b10 || bus.m0_stall !== 1'b1) begin
         errors++; $display("FAIL no_preempt: grant=%b m0_stall=%b want 10/1", bus.grant, bus.m0_stall);
      end
      bus.m0_cyc = 0; bus.m1_cyc = 0;
      step();
      checks++;
      if (bus.grant !== 2'b00) begin
         errors++; $display("FAIL release_m1: grant=%b want 00", bus.grant);
      end
      bus.m0_cyc = 1; bus.m1_cyc = 1;
      step();
      checks++;
      if (bus.grant !== 2'b01) begin
         errors++; $display("FAIL second_contention: grant=%b want 01", bus.grant);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      bus.m1_cyc = 1;
      step();
      bus.m1_stb = 1; bus.m1_we = 1; bus.m1_adr = 32'h0000_1000;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.m1_stall !== 1'b0 || bus.s_stb !== 1'b1) begin
            errors++; $display("FAIL accept_%0d: stall=%b s_stb=%b want 0/1", i, bus.m1_stall, bus.s_stb);
         end
         step();
      end
      #1;
      checks++;
      if (bus.m1_stall !== 1'b1 || bus.s_stb !== 1'b0) begin
         errors++; $display("FAIL full_stall: stall=%b s_stb=%b want 1/0", bus.m1_stall, bus.s_stb);
      end
      bus.s_ack = 1;
      #1;
      checks++;
      if (bus.m1_ack !== 1'b1 || bus.m1_stall !== 1'b1) begin
         errors++; $display("FAIL ack_when_full: ack=%b stall=%b want 1/1", bus.m1_ack, bus.m1_stall);
      end
      step();
      bus.s_ack = 0;
      #1;
      checks++;
      if (bus.m1_stall !== 1'b0 || bus.s_stb !== 1'b1) begin
         errors++; $display("FAIL fifth_accept: stall=%b s_stb=%b want 0/1", bus.m1_stall, bus.s_stb);
      end
      step();
      checks++;
      if (bus.m1_stall !== 1'b1) begin
         errors++; $display("FAIL refull: stall=%b want 1", bus.m1_stall);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      bus.m0_cyc = 1;
      step();
      bus.m0_stb = 1;
      #1;
      checks++;
      if (bus.s_stb !== 1'b1 || bus.m0_stall !== 1'b0) begin
         errors++; $display("FAIL tmo_accept: s_stb=%b stall=%b want 1/0", bus.s_stb, bus.m0_stall);
      end
      step();
      bus.m0_stb = 0;
      for (int k = 1; k <= TMO; k++) begin
         #1;
         checks++;
         if (bus.m0_err !== 1'(k == TMO)) begin
            errors++; $display("FAIL tmo_err_cycle_%0d: err=%b want %b", k, bus.m0_err, 1'(k == TMO));
         end
         if (k < TMO) step();
      end
      checks++;
      if (bus.s_cyc !== 1'b0) begin
         errors++; $display("FAIL tmo_cyc_drop: s_cyc=%b want 0", bus.s_cyc);
      end
      step();
      step();
      checks++;
      if ({bus.m0_err, bus.s_cyc, bus.m0_stall, bus.grant} !== 5'b00101) begin
         errors++; $display("FAIL tmo_hold: err/cyc/stall/grant=%b want 00101", {bus.m0_err, bus.s_cyc, bus.m0_stall, bus.grant});
      end
      bus.m0_cyc = 0;
      step();
      checks++;
      if (bus.grant !== 2'b00) begin
         errors++; $display("FAIL tmo_idle: grant=%b want 00", bus.grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.m1_cyc = 1;
      step();
      bus.m1_stb = 1;
      step();
      step();
      step();
      bus.m1_stb = 0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.s_cyc !== 1'b0 || bus.grant !== 2'b00) begin
         errors++; $display("FAIL async_reset: s_cyc=%b grant=%b want 0/00", bus.s_cyc, bus.grant);
      end
      step();
      step();
      rst_n = 1'b1; bus.s_ack = 1; bus.s_dat_r = 32'hcafe_f00d;
      #1;
      checks++;
      if (bus.m1_ack !== 1'b0 || bus.m1_dat_r !== 32'h0) begin
         errors++; $display("FAIL late_ack_idle: ack=%b dat=%h want 0/0", bus.m1_ack, bus.m1_dat_r);
      end
      step();
      checks++;
      if (bus.grant !== 2'b10 || bus.m1_ack !== 1'b0 || bus.m1_stall !== 1'b0) begin
         errors++; $display("FAIL late_ack_regrant: grant=%b ack=%b stall=%b want 10/0/0", bus.grant, bus.m1_ack, bus.m1_stall);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_random();
      int own, last, out, tmr;
      bit abort, c_own, stb_own, pend, rsp, exp_tmo, live, full, acc;
      logic [10:0] exp_v, got_v;
      logic [31:0] e_adr, e_d0, e_d1;
      do_reset();
      own = 0; last = 1; out = 0; tmr = 0; abort = 0;
      for (int n = 0; n < 2000; n++) begin
         bus.m0_cyc = bus.m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
         bus.m1_cyc = bus.m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
         bus.m0_stb = bus.m0_cyc && ($urandom_range(1) == 1);
         bus.m1_stb = bus.m1_cyc && ($urandom_range(1) == 1);
         bus.m0_we = 1'($urandom); bus.m1_we = 1'($urandom);
         bus.m0_adr = $urandom; bus.m1_adr = $urandom;
         bus.m0_sel = 4'($urandom); bus.m1_sel = 4'($urandom);
         bus.m0_dat_w = $urandom; bus.m1_dat_w = $urandom;
         bus.s_stall = ($urandom_range(3) == 0);
         bus.s_ack = ($urandom_range(9) < 3);
         bus.s_err = ($urandom_range(19) == 0);
         bus.s_dat_r = $urandom;
         #1;
         c_own   = (own == 1) ? bus.m0_cyc : (own == 2) ? bus.m1_cyc : 1'b0;
         stb_own = (own == 1) ? bus.m0_stb : (own == 2) ? bus.m1_stb : 1'b0;
         pend    = (out > 0);
         rsp     = (own != 0) && !abort && c_own && pend && (bus.s_ack || bus.s_err);
         exp_tmo = (own != 0) && !abort && c_own && pend && !rsp && (tmr == TMO - 1);
         live    = (own != 0) && !abort && !exp_tmo;
         full    = (out == MAXO);
         exp_v = {(own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00,
                  live && c_own,
                  live && stb_own && !full,
                  !(live && own == 1) || bus.s_stall || full,
                  !(live && own == 2) || bus.s_stall || full,
                  live && own == 1 && rsp && bus.s_ack,
                  live && own == 2 && rsp && bus.s_ack,
                  own == 1 && ((live && rsp && bus.s_err) || exp_tmo),
                  own == 2 && ((live && rsp && bus.s_err) || exp_tmo)};
         got_v = {bus.grant, bus.s_cyc, bus.s_stb, bus.m0_stall, bus.m1_stall,
                  bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL rand_ctl cycle %0d: got %b want %b (grant,cyc,stb,stall0,stall1,ack0,ack1,err0,err1)", n, got_v, exp_v);
         end
         e_adr = !live ? 32'h0 : (own == 1) ? bus.m0_adr : bus.m1_adr;
         e_d0  = (live && own == 1) ? bus.s_dat_r : 32'h0;
         e_d1  = (live && own == 2) ? bus.s_dat_r : 32'h0;
         checks++;
         if ({bus.s_adr, bus.m0_dat_r, bus.m1_dat_r} !== {e_adr, e_d0, e_d1}) begin
            errors++; $display("FAIL rand_data cycle %0d: adr=%h d0=%h d1=%h want %h %h %h",
               n, bus.s_adr, bus.m0_dat_r, bus.m1_dat_r, e_adr, e_d0, e_d1);
         end
         if (own == 0) begin
            if (bus.m0_cyc && bus.m1_cyc) own = (last == 1) ? 2 : 1;
            else if (bus.m0_cyc)          own = 1;
            else if (bus.m1_cyc)          own = 2;
            if (own != 0) last = own;
         end else if (!c_own) begin
            own = 0; out = 0; tmr = 0; abort = 0;
         end else if (exp_tmo) begin
            abort = 1; out = 0; tmr = 0;
         end else if (!abort) begin
            acc = live && stb_own && !full && !bus.s_stall;
            tmr = (!pend || rsp) ? 0 : tmr + 1;
            out = out + int'(acc) - int'(rsp);
         end
         step();
      end
      idle_inputs();
      step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_outstanding_limit();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
